// File: rtl/dual_port_rom_pkg.sv
// ----------------------------------------------------------------------------
// dual_port_rom_pkg
//   Shared geometry and contents of the dual-port lookup ROM.
//   ADDR_W / DATA_W : address and word widths (16 words x 8 bits)
//   NUM_PORTS       : number of independent read ports on the ROM
//   rom_word(addr)  : constant table entry, {~addr, addr}
// ----------------------------------------------------------------------------
package dual_port_rom_pkg;

   localparam int ADDR_W    = 4;
   localparam int DATA_W    = 8;
   localparam int NUM_PORTS = 2;

   // Spelled out as a 16-way case so synthesis maps it to a plain LUT/ROM
   // and the table is easy to audit against the decimal listing.
   function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] addr);
      logic [DATA_W-1:0] word;
      case (addr)
         4'd0:    word = 8'd240;
         4'd1:    word = 8'd225;
         4'd2:    word = 8'd210;
         4'd3:    word = 8'd195;
         4'd4:    word = 8'd180;
         4'd5:    word = 8'd165;
         4'd6:    word = 8'd150;
         4'd7:    word = 8'd135;
         4'd8:    word = 8'd120;
         4'd9:    word = 8'd105;
         4'd10:   word = 8'd90;
         4'd11:   word = 8'd75;
         4'd12:   word = 8'd60;
         4'd13:   word = 8'd45;
         4'd14:   word = 8'd30;
         4'd15:   word = 8'd15;
         default: word = '0;
      endcase
      return word;
   endfunction

endpackage

// File: rtl/dual_port_rom_read_port.sv
// ----------------------------------------------------------------------------
// rom_read_port
//   One synchronous read port of the constant ROM. The looked-up word is
//   captured on the rising edge when en is high and held otherwise; reset
//   clears the register and overrides en.
//   clk  : clock
//   rst  : synchronous active-high reset
//   en   : read enable
//   addr : word address
//   data : registered read data (1 cycle latency)
// ----------------------------------------------------------------------------
module rom_read_port
   import dual_port_rom_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data
);

   logic [DATA_W-1:0] data_reg;
   logic [DATA_W-1:0] data_next;

   always_comb begin
      data_next = data_reg;
      if (en) begin
         data_next = rom_word(addr);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_reg <= '0;
      end else begin
         data_reg <= data_next;
      end
   end

   // Output comes straight from the register: no input-to-output comb path.
   assign data = data_reg;

endmodule

// File: rtl/dual_port_rom.sv
// ----------------------------------------------------------------------------
// dual_port_rom
//   16 x 8 constant ROM with two independent registered read ports. The
//   ports share only the table contents, so both may read any address,
//   including the same one, in the same cycle.
//   clk          : clock
//   rst          : synchronous active-high reset (clears both outputs)
//   en_a / en_b  : port read enables
//   add_a/add_b  : port word addresses
//   d_ra / d_rb  : port read data, valid one cycle after an enabled edge
// ----------------------------------------------------------------------------
module dual_port_rom
   import dual_port_rom_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              en_a,
   input  logic              en_b,
   input  logic [ADDR_W-1:0] add_a,
   input  logic [ADDR_W-1:0] add_b,
   output logic [DATA_W-1:0] d_ra,
   output logic [DATA_W-1:0] d_rb
);

   // Index 0 is port A, index 1 is port B.
   logic [NUM_PORTS-1:0] en_v;
   logic [ADDR_W-1:0]    addr_v [NUM_PORTS];
   logic [DATA_W-1:0]    data_v [NUM_PORTS];

   assign en_v[0]   = en_a;
   assign en_v[1]   = en_b;
   assign addr_v[0] = add_a;
   assign addr_v[1] = add_b;
   assign d_ra      = data_v[0];
   assign d_rb      = data_v[1];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
         rom_read_port u_port (
            .clk  (clk),
            .rst  (rst),
            .en   (en_v[gi]),
            .addr (addr_v[gi]),
            .data (data_v[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_dual_port_rom.sv
// ----------------------------------------------------------------------------
// tb_dual_port_rom
//   Scoreboard bench for dual_port_rom. Each transaction drives both ports,
//   pushes the expected outputs (from a reference table and a per-port
//   hold/reset model) onto a queue, and pops/compares after the edge.
// ----------------------------------------------------------------------------
module tb_dual_port_rom;

   logic       clk;
   logic       rst;
   logic       en_a;
   logic       en_b;
   logic [3:0] add_a;
   logic [3:0] add_b;
   logic [7:0] d_ra;
   logic [7:0] d_rb;

   dual_port_rom dut (
      .clk   (clk),
      .rst   (rst),
      .en_a  (en_a),
      .en_b  (en_b),
      .add_a (add_a),
      .add_b (add_b),
      .d_ra  (d_ra),
      .d_rb  (d_rb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference contents, taken from the decimal listing of the table.
   int ref_tbl [16] = '{240, 225, 210, 195, 180, 165, 150, 135,
                        120, 105,  90,  75,  60,  45,  30,  15};

   typedef struct {
      logic [7:0] exp_a;
      logic [7:0] exp_b;
   } exp_t;

   exp_t       sb_q [$];
   logic [7:0] model_a;
   logic [7:0] model_b;
   int         n_checks;
   int         n_pass;
   int         n_txn;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // One transaction: drive, predict, clock, compare.
   task automatic txn(input string tag, input logic r, input logic ea, input logic [3:0] aa,
                      input logic eb, input logic [3:0] ab);
      exp_t e;
      exp_t p;
      rst   = r;
      en_a  = ea;
      add_a = aa;
      en_b  = eb;
      add_b = ab;
      if (r) begin
         model_a = 8'd0;
         model_b = 8'd0;
      end else begin
         if (ea) model_a = 8'(ref_tbl[aa]);
         if (eb) model_b = 8'(ref_tbl[ab]);
      end
      e.exp_a = model_a;
      e.exp_b = model_b;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         check({tag, "_empty_q"}, 8'd1, 8'd0);
      end else begin
         p = sb_q.pop_front();
         n_txn++;
         $display("txn %0d %s rst=%0b en_a=%0b add_a=%0d en_b=%0b add_b=%0d -> d_ra=%0d (exp %0d) d_rb=%0d (exp %0d)",
                  n_txn, tag, r, ea, aa, eb, ab, d_ra, p.exp_a, d_rb, p.exp_b);
         check({tag, "_a"}, d_ra, p.exp_a);
         check({tag, "_b"}, d_rb, p.exp_b);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_pass   = 0;
      n_txn    = 0;
      model_a  = 8'd0;
      model_b  = 8'd0;
      rst      = 1'b1;
      en_a     = 1'b0;
      en_b     = 1'b0;
      add_a    = 4'd0;
      add_b    = 4'd0;
      @(negedge clk);

      // Reset with enables high: reset wins on both edges.
      txn("rst0", 1'b1, 1'b1, 4'd7, 1'b1, 4'd7);
      txn("rst1", 1'b1, 1'b1, 4'd7, 1'b1, 4'd7);

      // Directed address pairs.
      txn("dir0", 1'b0, 1'b1, 4'd7,  1'b1, 4'd9);
      txn("dir1", 1'b0, 1'b1, 4'd8,  1'b1, 4'd2);
      txn("dir2", 1'b0, 1'b1, 4'd14, 1'b1, 4'd11);
      txn("dir3", 1'b0, 1'b1, 4'd15, 1'b1, 4'd6);
      txn("dir4", 1'b0, 1'b1, 4'd10, 1'b1, 4'd12);

      // Hold on port A while port B keeps reading.
      txn("hold0", 1'b0, 1'b1, 4'd3, 1'b1, 4'd4);
      txn("hold1", 1'b0, 1'b0, 4'd5, 1'b1, 4'd13);
      txn("hold2", 1'b0, 1'b0, 4'd5, 1'b1, 4'd1);

      // Same address on both ports.
      txn("same0", 1'b0, 1'b1, 4'd0, 1'b1, 4'd0);

      // Latency: an address change between edges must not reach the output.
      txn("lat0", 1'b0, 1'b1, 4'd2, 1'b1, 4'd2);
      add_a = 4'd9;
      #3;
      check("lat_mid_a", d_ra, 8'd210);
      txn("lat1", 1'b0, 1'b1, 4'd9, 1'b1, 4'd2);

      // Sweep, port B reversed, with a single reset edge mid-way.
      for (int i = 0; i < 16; i++) begin
         if (i == 8) begin
            txn("sweep_rst", 1'b1, 1'b1, 4'(i), 1'b1, 4'(15 - i));
         end
         txn($sformatf("sweep%0d", i), 1'b0, 1'b1, 4'(i), 1'b1, 4'(15 - i));
      end

      if (sb_q.size() != 0) begin
         check("sb_q_leftover", 8'(sb_q.size()), 8'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
